filter_fifo: RTL and testbench
==============================

# filter_fifo

Synchronous single-clock FIFO buffering 16-bit samples between producer and consumer stages of the filter datapath. Writes and reads share one clock, with full/empty status registered off the same edge. Read data is registered (one-cycle read latency) unless first-word-fall-through is compiled in.

## Interface
Parameters:
- DATA_W, 16, word width.
- ADDR_W, 4, pointer width; depth = 2**ADDR_W (16 entries).

Ports:
- fifo_clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- fifo_wren  in  1  write request, sampled at rising edge.
- fifo_wrdata  in  DATA_W  write data, sampled with fifo_wren.
- fifo_rden  in  1  read request, sampled at rising edge.
- fifo_rddata  out  DATA_W  read data.
- fifo_full  out  1  high when the FIFO holds 2**ADDR_W words.
- fifo_empty  out  1  high when the FIFO holds 0 words.

## Operation
- Storage: 2**ADDR_W x DATA_W register array.
- State: write pointer, read pointer (ADDR_W bits each), occupancy count (ADDR_W+1 bits).
- Accepted write = fifo_wren & !fifo_full. Stores fifo_wrdata at the write pointer, then increments the pointer.
- Accepted read = fifo_rden & !fifo_empty. Loads mem[read pointer] into fifo_rddata, then increments the pointer.
- Flags are evaluated from the state before the edge. A write while full is dropped, and so is a read while empty. Neither changes state, and fifo_rddata holds its last value.
- Simultaneous accepted read and write: both execute and the count is unchanged.
- Simultaneous request while empty: only the write is accepted; the read is ignored.
- Simultaneous request while full: only the read is accepted; the write is dropped.
- Pointers wrap modulo 2**ADDR_W. The count saturates naturally because accepts are gated by the flags.
- fifo_empty = (count == 0); fifo_full = (count == 2**ADDR_W). Both are driven from registered count or flag registers, with no combinational path from the request inputs.
- Memory contents are not reset.

## Timing
- Reset (rst = 0, asynchronous): pointers and count = 0, fifo_rddata = 0, fifo_empty = 1, fifo_full = 0. Reset takes effect immediately and discards data mid-operation. Release is synchronous to the next rising edge, and operation begins on the first edge with rst = 1.
- Write latency: a word written at edge N makes fifo_empty fall after edge N. It is readable by a request sampled at edge N+1.
- Read latency: with fifo_rden sampled at edge N, fifo_rddata is valid after edge N and is held until the next accepted read or reset.
- fifo_full rises after the edge that accepts the 2**ADDR_W-th word, and falls after the edge of the next accepted read.
- Requests are level-sampled. Holding fifo_rden high for k edges performs k reads, subject to the empty gating.

## Configuration
- FIFO_FWFT_EN, when defined, selects first-word-fall-through:
  - fifo_rddata = mem[read pointer] combinationally whenever !fifo_empty.
  - An accepted read advances the pointer only, so the next word appears after that edge.
  - While empty, fifo_rddata holds the last presented word (0 after reset).
- Without FIFO_FWFT_EN: registered read with one-cycle latency, as above.

## Test plan
- Reset: assert rst = 0 mid-stream with 3 words stored -> immediately fifo_empty = 1, fifo_full = 0, fifo_rddata = 0; the next read returns nothing new.
- Write/read order: write 24, idle, write 4, then read twice with single-edge fifo_rden pulses -> fifo_rddata = 24 then 4, and fifo_empty = 1 after the second read.
- Read on empty: after the previous scenario, pulse fifo_rden -> fifo_rddata stays 4, fifo_empty stays 1, pointers unchanged.
- Fill and overflow: write 0..15 -> fifo_full = 1 after the 16th write. A 17th write of 99 is dropped, and reading 16 words returns 0..15 in order.
- Wrap and simultaneous requests: cycle 40 words with fifo_wren = fifo_rden = 1 at occupancy 1 -> count stays 1 and data emerges in write order across pointer wrap. Simultaneous requests while empty accept only the write.
- FWFT build (FIFO_FWFT_EN): write 7 -> fifo_rddata = 7 after that edge with no read issued; a read then advances the pointer and fifo_empty = 1.

Source files
------------

// File: rtl/filter_fifo_if.sv
// filter_fifo_if: write/read handshake and status bundle for filter_fifo.
interface filter_fifo_if #(parameter int DATA_W = 16);
  logic              fifo_wren;
  logic [DATA_W-1:0] fifo_wrdata;
  logic              fifo_rden;
  logic [DATA_W-1:0] fifo_rddata;
  logic              fifo_full;
  logic              fifo_empty;
  modport master (output fifo_wren, fifo_wrdata, fifo_rden, input fifo_rddata, fifo_full, fifo_empty);
  modport slave  (input fifo_wren, fifo_wrdata, fifo_rden, output fifo_rddata, fifo_full, fifo_empty);
endinterface

// File: rtl/filter_fifo.sv
// filter_fifo: single-clock sample FIFO with registered read; define FIFO_FWFT_EN for first-word-fall-through.
module filter_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              fifo_clk,
  input  logic              rst,
  filter_fifo_if.slave      bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] rdata_q;
  logic              wr_acc, rd_acc;
  assign bus.fifo_empty = count == '0;
  assign bus.fifo_full  = count == FULL_CNT;
  assign wr_acc = bus.fifo_wren & ~bus.fifo_full;
  assign rd_acc = bus.fifo_rden & ~bus.fifo_empty;
  always_ff @(posedge fifo_clk)
    if (wr_acc) mem[wr_ptr] <= bus.fifo_wrdata;
  // rdata_q is the read result in registered mode and the last presented word in FWFT mode
  always_ff @(posedge fifo_clk or negedge rst)
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rdata_q <= mem[rd_ptr];
      end
      count <= count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    end
`ifdef FIFO_FWFT_EN
  assign bus.fifo_rddata = bus.fifo_empty ? rdata_q : mem[rd_ptr];
`else
  assign bus.fifo_rddata = rdata_q;
`endif
endmodule

// File: tb/tb_filter_fifo.sv
// tb_filter_fifo: directed table-driven checks of filter_fifo (registered-read build).
module tb_filter_fifo;
  logic fifo_clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  filter_fifo_if #(.DATA_W(16)) bus ();
  filter_fifo #(.DATA_W(16), .ADDR_W(4)) dut (.fifo_clk(fifo_clk), .rst(rst), .bus(bus));
  always #5 fifo_clk = ~fifo_clk;
  typedef struct {
    bit          wren;
    logic [15:0] wd;
    bit          rden;
    logic [15:0] rd;
    bit          e;
    bit          f;
  } vec_t;
  vec_t vecs [9];
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input bit w, input logic [15:0] d, input bit r);
    bus.fifo_wren   = w;
    bus.fifo_wrdata = d;
    bus.fifo_rden   = r;
    @(posedge fifo_clk);
    #1;
    bus.fifo_wren = 1'b0;
    bus.fifo_rden = 1'b0;
  endtask
  task automatic flags(input string name, input logic [15:0] rd, input bit e, input bit f);
    check({name, "_rddata"}, bus.fifo_rddata, rd);
    check({name, "_empty"}, 16'(bus.fifo_empty), 16'(e));
    check({name, "_full"}, 16'(bus.fifo_full), 16'(f));
  endtask
  initial begin
    vecs[0] = '{0, 16'd0,  0, 16'd0,  1, 0};
    vecs[1] = '{1, 16'd24, 0, 16'd0,  0, 0};
    vecs[2] = '{0, 16'd0,  0, 16'd0,  0, 0};
    vecs[3] = '{1, 16'd4,  0, 16'd0,  0, 0};
    vecs[4] = '{0, 16'd0,  1, 16'd24, 0, 0};
    vecs[5] = '{0, 16'd0,  1, 16'd4,  1, 0};
    vecs[6] = '{0, 16'd0,  1, 16'd4,  1, 0};
    vecs[7] = '{1, 16'd55, 1, 16'd4,  0, 0};
    vecs[8] = '{0, 16'd0,  1, 16'd55, 1, 0};
    bus.fifo_wren = 1'b0;
    bus.fifo_wrdata = '0;
    bus.fifo_rden = 1'b0;
    repeat (2) @(posedge fifo_clk);
    #1;
    flags("reset", 16'd0, 1, 0);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].wren, vecs[i].wd, vecs[i].rden);
      flags($sformatf("vec%0d", i), vecs[i].rd, vecs[i].e, vecs[i].f);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1, 16'(i), 0);
      check($sformatf("fill_full%0d", i), 16'(bus.fifo_full), 16'(i == 15));
    end
    cyc(1, 16'd99, 0);
    flags("overflow", 16'd55, 0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1);
      flags($sformatf("drain%0d", i), 16'(i), i == 15, 0);
    end
    for (int i = 0; i < 16; i++) cyc(1, 16'(100 + i), 0);
    cyc(1, 16'd77, 1);
    flags("full_simul", 16'd100, 0, 0);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 1);
      flags($sformatf("full_drain%0d", i), 16'(100 + i), i == 15, 0);
    end
    cyc(1, 16'd200, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 16'(201 + i), 1);
      flags($sformatf("wrap%0d", i), 16'(200 + i), 0, 0);
    end
    cyc(0, 0, 1);
    flags("wrap_last", 16'd240, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 16'(i), 0);
    cyc(0, 0, 1);
    flags("pre_rst", 16'd1, 0, 0);
    #3 rst = 1'b0;
    #1;
    flags("async_rst", 16'd0, 1, 0);
    #2 rst = 1'b1;
    @(posedge fifo_clk);
    #1;
    cyc(0, 0, 1);
    flags("post_rst_read", 16'd0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
